// File: rtl/tl_pkg.sv
// TileLink-UL shared types: channel A/D opcodes and the size-to-lane mask helper.
// Imported by the RAM slave, the interconnect and the MMU.
package tl_pkg;

    typedef enum logic [2:0] {
        PUT_FULL    = 3'd0,
        PUT_PARTIAL = 3'd1,
        GET         = 3'd4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        ACK      = 3'd0,
        ACK_DATA = 3'd1
    } tl_d_op_e;

    // Byte lanes touched by a naturally sized access within a 64-bit beat.
    function automatic logic [7:0] size_mask(input logic [2:0] size,
                                             input logic [2:0] addr_lo);
        logic [7:0] m;
        case (size)
            3'd0:    m = 8'h01;
            3'd1:    m = 8'h03;
            3'd2:    m = 8'h0F;
            3'd3:    m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m << addr_lo;
    endfunction

endpackage

// File: rtl/sp_ram.sv
// 64-bit single-port RAM: byte-enable write port, one-cycle synchronous read port.
module sp_ram #(
    parameter int    DEPTH     = 4096,
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [7:0]               be,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [63:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [63:0]              rdata
);

    logic [63:0] mem [DEPTH];
    logic [63:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tl_ram_slave.sv
// TileLink-UL responder for a 64-bit on-chip RAM, one request in flight.
module tl_ram_slave
    import tl_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 1,
    parameter int          SRC_W     = 4,
    parameter string       INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [2:0]       a_opcode,
    input  logic [2:0]       a_size,
    input  logic [SRC_W-1:0] a_source,
    input  logic [63:0]      a_address,
    input  logic [7:0]       a_mask,
    input  logic [63:0]      a_data,
    output logic             d_valid,
    input  logic             d_ready,
    output logic [2:0]       d_opcode,
    output logic [2:0]       d_size,
    output logic [SRC_W-1:0] d_source,
    output logic             d_denied,
    output logic [63:0]      d_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);
    localparam logic [63:0] END_ADDR = BASE_ADDR + (64'(DEPTH) << 3);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [2:0]       size_q, size_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [7:0]       be_q, be_d;
    logic [63:0]      wdata_q, wdata_d;
    logic             deny_q, deny_d;
    tl_d_op_e         d_op_q, d_op_d;
    logic [2:0]       d_size_q, d_size_d;
    logic [SRC_W-1:0] d_src_q, d_src_d;
    logic             d_deny_q, d_deny_d;
    logic [63:0]      d_data_q, d_data_d;

    logic [63:0]   a_off;
    logic [AW-1:0] a_idx;
    logic [2:0]    a_lo_m;
    logic          a_op_ok;
    logic          a_deny;
    logic [7:0]    a_be;
    logic          is_get;
    logic          ram_we;
    logic [AW-1:0] ram_raddr;
    logic [63:0]   ram_rdata;

    assign a_off   = a_address - BASE_ADDR;
    assign a_idx   = AW'(a_off >> 3);
    assign a_lo_m  = 3'((8'd1 << a_size) - 8'd1);
    assign a_op_ok = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL)
                  || (a_opcode == GET);
    assign a_deny  = (a_address < BASE_ADDR) || (a_address >= END_ADDR)
                  || (|(a_address[2:0] & a_lo_m)) || (a_size > 3'd3)
                  || !a_op_ok;
    assign a_be    = (a_opcode == PUT_PARTIAL) ? a_mask
                                               : size_mask(a_size, a_address[2:0]);
    assign is_get  = (op_q == GET);

    // Read the incoming word while idle so data is ready by the end of WAIT.
    assign ram_raddr = (state_q == S_IDLE) ? a_idx : idx_q;

    sp_ram #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (be_q),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        size_d   = size_q;
        src_d    = src_q;
        idx_d    = idx_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        deny_d   = deny_q;
        d_op_d   = d_op_q;
        d_size_d = d_size_q;
        d_src_d  = d_src_q;
        d_deny_d = d_deny_q;
        d_data_d = d_data_q;
        ram_we   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (a_valid) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    op_d    = a_opcode;
                    size_d  = a_size;
                    src_d   = a_source;
                    idx_d   = a_idx;
                    be_d    = a_be;
                    wdata_d = a_data;
                    deny_d  = a_deny;
                end
            end
            S_WAIT: begin
                if (cnt_q == LAST) begin
                    state_d  = S_RESP;
                    ram_we   = !deny_q && !is_get;
                    d_op_d   = is_get ? ACK_DATA : ACK;
                    d_size_d = size_q;
                    d_src_d  = src_q;
                    d_deny_d = deny_q;
                    d_data_d = (is_get && !deny_q) ? ram_rdata : 64'd0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (d_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            size_q   <= '0;
            src_q    <= '0;
            idx_q    <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            deny_q   <= 1'b0;
            d_op_q   <= ACK;
            d_size_q <= '0;
            d_src_q  <= '0;
            d_deny_q <= 1'b0;
            d_data_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            size_q   <= size_d;
            src_q    <= src_d;
            idx_q    <= idx_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            deny_q   <= deny_d;
            d_op_q   <= d_op_d;
            d_size_q <= d_size_d;
            d_src_q  <= d_src_d;
            d_deny_q <= d_deny_d;
            d_data_q <= d_data_d;
        end
    end

    assign a_ready  = (state_q == S_IDLE);
    assign d_valid  = (state_q == S_RESP);
    assign d_opcode = d_op_q;
    assign d_size   = d_size_q;
    assign d_source = d_src_q;
    assign d_denied = d_deny_q;
    assign d_data   = d_data_q;

endmodule

// File: tb/tb_tl_ram_slave.sv
// Randomized TileLink-UL bench for tl_ram_slave against a byte-level memory model.
module tb_tl_ram_slave;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;
    localparam int          SW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid;
    logic          a_ready;
    logic [2:0]    a_opcode;
    logic [2:0]    a_size;
    logic [SW-1:0] a_source;
    logic [63:0]   a_address;
    logic [7:0]    a_mask;
    logic [63:0]   a_data;
    logic          d_valid;
    logic          d_ready;
    logic [2:0]    d_opcode;
    logic [2:0]    d_size;
    logic [SW-1:0] d_source;
    logic          d_denied;
    logic [63:0]   d_data;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] mem_m [int];

    always #5 clk = ~clk;

    tl_ram_slave #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT),
        .SRC_W     (SW),
        .INIT_FILE ("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_denied  (d_denied),
        .d_data    (d_data)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, ".a_ready"}, 64'(a_ready), 64'd1);
        check({tag, ".d_valid"}, 64'(d_valid), 64'd0);
        check({tag, ".d_opcode"}, 64'(d_opcode), 64'd0);
        check({tag, ".d_size"}, 64'(d_size), 64'd0);
        check({tag, ".d_source"}, 64'(d_source), 64'd0);
        check({tag, ".d_denied"}, 64'(d_denied), 64'd0);
        check({tag, ".d_data"}, d_data, 64'd0);
    endtask

    function automatic bit exp_deny(input logic [2:0] op, input logic [2:0] sz,
                                    input logic [63:0] addr);
        logic [63:0] lim;
        lim = BASE + 64'(DEPTH) * 64'd8;
        if (addr < BASE || addr >= lim) return 1'b1;
        if (sz > 3) return 1'b1;
        if (addr % (64'd1 << sz) != 0) return 1'b1;
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b1;
        return 1'b0;
    endfunction

    // Issue one request (caller sits 1 time unit after a rising edge) and check the response.
    task automatic req(input string tag, input logic [2:0] op, input logic [2:0] sz,
                       input logic [SW-1:0] src, input logic [63:0] addr,
                       input logic [7:0] mask, input logic [63:0] data,
                       input int hold);
        bit          dn;
        int          w;
        int          lo;
        int          lat;
        logic [63:0] exp_d;
        logic [63:0] word;
        dn    = exp_deny(op, sz, addr);
        w     = int'((addr - BASE) >> 3);
        lo    = int'(addr % 8);
        exp_d = 64'd0;
        if (!dn && op == 3'd4) exp_d = mem_m[w];
        if (!dn && op != 3'd4) begin
            word = mem_m.exists(w) ? mem_m[w] : 64'd0;
            for (int b = 0; b < 8; b++) begin
                if ((op == 3'd1) ? mask[b] : (b >= lo && b < lo + (1 << sz)))
                    word[8*b +: 8] = data[8*b +: 8];
            end
            mem_m[w] = word;
        end
        a_valid   = 1'b1;
        a_opcode  = op;
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        check({tag, ".a_ready"}, 64'(a_ready), 64'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_data  = ~data;
        lat     = 0;
        while (!d_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(LAT));
        if (!d_valid) return;
        check({tag, ".d_opcode"}, 64'(d_opcode), (op == 3'd4) ? 64'd1 : 64'd0);
        check({tag, ".d_size"}, 64'(d_size), 64'(sz));
        check({tag, ".d_source"}, 64'(d_source), 64'(src));
        check({tag, ".d_denied"}, 64'(d_denied), 64'(dn));
        check({tag, ".d_data"}, d_data, exp_d);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_a_ready"}, 64'(a_ready), 64'd0);
            check({tag, ".hold_d_valid"}, 64'(d_valid), 64'd1);
            check({tag, ".hold_d_data"}, d_data, exp_d);
            check({tag, ".hold_d_source"}, 64'(d_source), 64'(src));
        end
        d_ready = 1'b1;
        @(posedge clk);
        #1;
        d_ready = 1'b0;
        check({tag, ".ack_a_ready"}, 64'(a_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] addr;
        logic [2:0]  op;
        logic [2:0]  sz;
        int          k;
        int          dv_cnt;
        rst       = 1'b1;
        a_valid   = 1'b0;
        a_opcode  = '0;
        a_size    = '0;
        a_source  = '0;
        a_address = BASE;
        a_mask    = '0;
        a_data    = '0;
        d_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        reset_checks("post_reset");

        for (int i = 0; i < 32; i++)
            req("preload", 3'd0, 3'd3, 4'(i), BASE + 64'(i) * 8, 8'h00,
                {$urandom(), $urandom()}, 0);
        req("preload_top", 3'd0, 3'd3, 4'h1, BASE + 64'(DEPTH - 1) * 8, 8'h00,
            {$urandom(), $urandom()}, 0);

        req("get_pre_put", 3'd0, 3'd3, 4'h3, BASE + 64'h10, 8'h00,
            64'h1122_3344_5566_7788, 0);
        req("get_pre", 3'd4, 3'd3, 4'hA, BASE + 64'h10, 8'h00, 64'd0, 0);
        check("get_pre.value", mem_m[2], 64'h1122_3344_5566_7788);

        req("pp_zero", 3'd0, 3'd3, 4'h2, BASE + 64'h8, 8'h00, 64'd0, 0);
        req("pp_put", 3'd1, 3'd3, 4'h5, BASE + 64'h8, 8'h0F,
            64'hFFFF_FFFF_AAAA_BBBB, 0);
        req("pp_get", 3'd4, 3'd3, 4'h6, BASE + 64'h8, 8'h00, 64'd0, 0);
        check("pp.value", mem_m[1], 64'h0000_0000_AAAA_BBBB);

        req("pf_init", 3'd0, 3'd3, 4'h7, BASE, 8'h00, 64'h0123_4567_89AB_CDEF, 0);
        req("pf_half", 3'd0, 3'd1, 4'h8, BASE + 64'h6, 8'h00,
            64'hBEEF_0000_0000_0000, 0);
        req("pf_get", 3'd4, 3'd3, 4'h9, BASE, 8'h00, 64'd0, 0);
        check("pf.value", mem_m[0], 64'hBEEF_4567_89AB_CDEF);

        req("deny_range", 3'd4, 3'd3, 4'hB, BASE + 64'(DEPTH) * 8, 8'h00, 64'd0, 0);
        req("deny_align", 3'd4, 3'd2, 4'hC, BASE + 64'h2, 8'h00, 64'd0, 0);
        req("deny_op", 3'd2, 3'd3, 4'hD, BASE, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, 0);
        req("deny_alias", 3'd0, 3'd3, 4'hE, BASE + 64'(DEPTH) * 8, 8'h00,
            64'hCAFE_CAFE_CAFE_CAFE, 0);
        req("deny_misput", 3'd0, 3'd3, 4'hF, BASE + 64'h1, 8'h00,
            64'h5A5A_5A5A_5A5A_5A5A, 0);
        req("deny_low", 3'd1, 3'd3, 4'h0, BASE - 64'h8, 8'hFF, 64'h1, 0);
        req("deny_chk", 3'd4, 3'd3, 4'h1, BASE, 8'h00, 64'd0, 0);

        req("hold", 3'd4, 3'd3, 4'h4, BASE + 64'h18, 8'h00, 64'd0, 5);
        req("after_hold", 3'd4, 3'd3, 4'h5, BASE + 64'h20, 8'h00, 64'd0, 0);

        a_valid   = 1'b1;
        a_opcode  = 3'd0;
        a_size    = 3'd3;
        a_source  = 4'h6;
        a_address = BASE + 64'h28;
        a_mask    = 8'hFF;
        a_data    = ~mem_m[5];
        check("rst_mid.a_ready", 64'(a_ready), 64'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        rst     = 1'b1;
        #1;
        reset_checks("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        dv_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (d_valid) dv_cnt++;
        end
        check("rst_mid.no_d_beat", 64'(dv_cnt), 64'd0);
        req("rst_mid_get", 3'd4, 3'd3, 4'h7, BASE + 64'h28, 8'h00, 64'd0, 0);

        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 9);
            if (k < 4) op = 3'd4;
            else if (k < 6) op = 3'd0;
            else if (k < 8) op = 3'd1;
            else if (k < 9) op = 3'd4;
            else op = 3'(($urandom_range(0, 1) == 0) ? $urandom_range(2, 3)
                                                     : $urandom_range(5, 7));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                             : 3'($urandom_range(0, 3));
            k = $urandom_range(0, 19);
            if (k == 0) addr = BASE - 64'($urandom_range(1, 4)) * 8;
            else if (k == 1) addr = BASE + 64'(DEPTH + $urandom_range(0, 15)) * 8;
            else if (k == 2) addr = BASE + 64'(DEPTH - 1) * 8;
            else addr = BASE + 64'($urandom_range(0, 31)) * 8;
            addr = addr + 64'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0 && sz <= 3)
                addr = addr & ~((64'd1 << sz) - 64'd1);
            req("rand", op, sz, 4'($urandom_range(0, 15)), addr,
                8'($urandom_range(0, 255)), {$urandom(), $urandom()},
                ($urandom_range(0, 4) == 0) ? 2 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
